// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the scoreboard 7-segment scan controller:
// the blank code, the scan FSM state type and the leading-zero blanking helper.
package scoreboard_disp_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        OFF,
        DRIVE,
        GUARD
    } scan_state_t;

    // Replaces zeros with BLANK_CODE from the most significant used digit downward,
    // stopping at the first nonzero digit; digit 0 always keeps its value.
    function automatic logic [4*MAX_DIGITS-1:0] blank_leading_zeros(
        input logic [4*MAX_DIGITS-1:0] digits,
        input int                      num_digits
    );
        logic [4*MAX_DIGITS-1:0] result;
        logic                    leading;
        result  = digits;
        leading = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                if (leading && (digits[4*i +: 4] == 4'h0)) begin
                    result[4*i +: 4] = BLANK_CODE;
                end else begin
                    leading = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// Dwell counter for the scan controller. Counts enabled cycles and raises tc
// on the last cycle of a 'limit'-cycle interval, then restarts from zero.
module scan_prescaler
    import scoreboard_disp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = en && !clear && (count == (limit - 1'b1));

    // Count enabled cycles, wrapping to zero on terminal count or when cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one
// BCD decoder. Scores load into a shadow register and commit at frame wrap (or
// immediately while dark) so a displayed value never tears.
// Optional macro DISPLAY_SCAN_LZB_EN enables leading-zero blanking at commit.
module display_scan_ctrl
    import scoreboard_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    output logic [3:0]                    dig_bcd,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
    output logic                          pending,
    output logic                          frame_tick
);

    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int MAX_DWELL = (PRESCALE > GUARD_CYCLES) ? PRESCALE : GUARD_CYCLES;
    localparam int CNT_W     = $clog2(MAX_DWELL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [4*NUM_DIGITS-1:0]   active;
    logic [4*NUM_DIGITS-1:0]   commit_val;
    logic [4*NUM_DIGITS-1:0]   active_nxt;
    logic [IDX_W-1:0]          next_idx;
    logic [CNT_W-1:0]          dwell_limit;
    logic                      dwell_clear;
    logic                      dwell_en;
    logic                      dwell_done;
    logic                      wrap;
    logic                      do_commit;

    function automatic logic [3:0] digit_at(
        input logic [4*NUM_DIGITS-1:0] digits,
        input logic [IDX_W-1:0]        idx
    );
        logic [3:0] code;
        code = BLANK_CODE;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) code = digits[4*k +: 4];
        end
        return code;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] mask;
        mask = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) mask[k] = 1'b0;
        end
        return mask;
    endfunction

    assign dwell_en    = (state != OFF);
    assign dwell_clear = !enable || (state == OFF);
    assign dwell_limit = (state == DRIVE) ? CNT_W'(PRESCALE) : CNT_W'(GUARD_CYCLES);
    assign next_idx    = dig_idx + 1'b1;
    assign wrap        = enable && (state == GUARD) && dwell_done && (dig_idx == LAST_IDX);
    assign do_commit   = pending && ((state == OFF) || wrap);
    assign active_nxt  = do_commit ? commit_val : active;

    scan_prescaler #(
        .WIDTH (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (dwell_clear),
        .en    (dwell_en),
        .limit (dwell_limit),
        .tc    (dwell_done)
    );

`ifdef DISPLAY_SCAN_LZB_EN
    logic [4*MAX_DIGITS-1:0] shadow_wide;
    logic [4*MAX_DIGITS-1:0] lzb_wide;
    logic                    lzb_unused;

    // Widen the shadow to the helper's fixed width, upper digits zero.
    always_comb begin
        shadow_wide                   = '0;
        shadow_wide[4*NUM_DIGITS-1:0] = shadow;
    end

    assign lzb_wide   = blank_leading_zeros(shadow_wide, NUM_DIGITS);
    assign commit_val = lzb_wide[4*NUM_DIGITS-1:0];
    assign lzb_unused = ^lzb_wide;
`else
    assign commit_val = shadow;
`endif

    // Shadow capture on load and commit into the active register; a load in a
    // commit cycle keeps pending set because the commit took the older shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '1;
            pending <= 1'b0;
        end else begin
            active <= active_nxt;
            if (load) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end else if (do_commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Scan sequencer: DRIVE one digit, GUARD with all digits dark, advance and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            an         <= '1;
            dig_bcd    <= BLANK_CODE;
            dig_idx    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!enable) begin
                state   <= OFF;
                an      <= '1;
                dig_bcd <= BLANK_CODE;
                dig_idx <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state   <= DRIVE;
                        dig_idx <= '0;
                        an      <= digit_enable('0);
                        dig_bcd <= active_nxt[3:0];
                    end
                    DRIVE: begin
                        if (dwell_done) begin
                            state   <= GUARD;
                            an      <= '1;
                            dig_bcd <= BLANK_CODE;
                        end
                    end
                    GUARD: begin
                        if (dwell_done) begin
                            state <= DRIVE;
                            if (dig_idx == LAST_IDX) begin
                                dig_idx    <= '0;
                                an         <= digit_enable('0);
                                dig_bcd    <= active_nxt[3:0];
                                frame_tick <= 1'b1;
                            end else begin
                                dig_idx <= next_idx;
                                an      <= digit_enable(next_idx);
                                dig_bcd <= digit_at(active, next_idx);
                            end
                        end
                    end
                    default: begin
                        state   <= OFF;
                        an      <= '1;
                        dig_bcd <= BLANK_CODE;
                        dig_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 4-cycle dwell, 1-cycle guard).
// A time-based model predicts every output each cycle; directed scenarios pin it
// with literal values, then a randomized phase exercises loads and enable drops.
module tb_display_scan_ctrl;

    localparam int NUMD  = 4;
    localparam int PRE   = 4;
    localparam int GRD   = 1;
    localparam int SLOT  = PRE + GRD;
    localparam int FRAME = NUMD * SLOT;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] bcd_in  = 16'h0000;
    logic [3:0]  dig_bcd;
    logic [3:0]  an;
    logic [1:0]  dig_idx;
    logic        pending;
    logic        frame_tick;

    int checkCount = 0;
    int errCount   = 0;

    // Model state: scanning flag, cycle position within the frame, registers.
    bit         mOn;
    int         mT;
    logic       mPending;
    logic       mTick;
    logic [3:0] mShadow [NUMD];
    logic [3:0] mActive [NUMD];

    display_scan_ctrl #(
        .NUM_DIGITS   (NUMD),
        .PRESCALE     (PRE),
        .GUARD_CYCLES (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .bcd_in     (bcd_in),
        .dig_bcd    (dig_bcd),
        .an         (an),
        .dig_idx    (dig_idx),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] data);
        enable = en;
        load   = ld;
        bcd_in = data;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        mOn      = 1'b0;
        mT       = 0;
        mPending = 1'b0;
        mTick    = 1'b0;
        for (int i = 0; i < NUMD; i++) begin
            mShadow[i] = 4'h0;
            mActive[i] = 4'hF;
        end
    endtask

    task automatic modelCommit();
        logic leading;
        leading = 1'b1;
        for (int i = NUMD - 1; i >= 0; i--) begin
            if (LZB && leading && (i > 0) && (mShadow[i] == 4'h0)) begin
                mActive[i] = 4'hF;
            end else begin
                mActive[i] = mShadow[i];
                leading    = 1'b0;
            end
        end
    endtask

    task automatic modelStep(input logic en, input logic ld, input logic [15:0] data);
        logic doCommit;
        doCommit = 1'b0;
        mTick    = 1'b0;
        if (!mOn) begin
            doCommit = mPending;
            if (en) begin
                mOn = 1'b1;
                mT  = 0;
            end
        end else if (!en) begin
            mOn = 1'b0;
            mT  = 0;
        end else begin
            mT = (mT + 1) % FRAME;
            if (mT == 0) begin
                mTick    = 1'b1;
                doCommit = mPending;
            end
        end
        if (doCommit) begin
            modelCommit();
            mPending = 1'b0;
        end
        if (ld) begin
            for (int i = 0; i < NUMD; i++) mShadow[i] = data[4*i +: 4];
            mPending = 1'b1;
        end
    endtask

    task automatic compareModel();
        logic [3:0] eAn;
        logic [3:0] eBcd;
        int         d;
        eAn  = 4'hF;
        eBcd = 4'hF;
        d    = 0;
        if (mOn) begin
            d = mT / SLOT;
            if ((mT % SLOT) < PRE) begin
                eAn  = ~(4'b0001 << d);
                eBcd = mActive[d];
            end
        end
        checkOutput("model an", 32'(an), 32'(eAn));
        checkOutput("model dig_bcd", 32'(dig_bcd), 32'(eBcd));
        checkOutput("model dig_idx", 32'(dig_idx), 32'(d));
        checkOutput("model pending", 32'(pending), 32'(mPending));
        checkOutput("model frame_tick", 32'(frame_tick), 32'(mTick));
    endtask

    function automatic logic [15:0] randBcd();
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < NUMD; i++) begin
            if ($urandom_range(0, 9) >= 4) v[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Reference model advances on every clock edge and clears on async reset.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep(enable, load, bcd_in);
        end
    end

    // Compare every output against the model on each falling edge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) compareModel();
        end
    end

    initial begin
        logic [3:0] hiZero;
        hiZero = LZB ? 4'hF : 4'h0;

        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("reset an", 32'(an), 32'hF);
        checkOutput("reset dig_bcd", 32'(dig_bcd), 32'hF);
        checkOutput("reset dig_idx", 32'(dig_idx), 32'h0);
        checkOutput("reset pending", 32'(pending), 32'h0);
        checkOutput("reset frame_tick", 32'(frame_tick), 32'h0);

        // Scan with no load: blank digits, 4-on / 1-off dwell, tick every 20 cycles.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(1);
        checkOutput("scan t0 an", 32'(an), 32'b1110);
        checkOutput("scan t0 dig_bcd", 32'(dig_bcd), 32'hF);
        waitCycles(4);
        checkOutput("scan t4 guard an", 32'(an), 32'b1111);
        waitCycles(1);
        checkOutput("scan t5 an", 32'(an), 32'b1101);
        checkOutput("scan t5 dig_idx", 32'(dig_idx), 32'h1);
        waitCycles(15);
        checkOutput("scan t20 frame_tick", 32'(frame_tick), 32'h1);
        checkOutput("scan t20 an", 32'(an), 32'b1110);

        // Mid-frame load while digit 2 is driven; commit at the next wrap.
        waitCycles(11);
        applyStimulus(1'b1, 1'b1, 16'h1234);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("load pending set", 32'(pending), 32'h1);
        waitCycles(7);
        checkOutput("load pending held", 32'(pending), 32'h1);
        waitCycles(1);
        checkOutput("commit frame_tick", 32'(frame_tick), 32'h1);
        checkOutput("commit pending clr", 32'(pending), 32'h0);
        checkOutput("1234 digit0", 32'(dig_bcd), 32'h4);
        waitCycles(5);
        checkOutput("1234 digit1", 32'(dig_bcd), 32'h3);
        waitCycles(5);
        checkOutput("1234 digit2", 32'(dig_bcd), 32'h2);
        waitCycles(5);
        checkOutput("1234 digit3", 32'(dig_bcd), 32'h1);

        // Two loads in one frame: the last one wins.
        applyStimulus(1'b1, 1'b1, 16'h0001);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 16'h0099);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(3);
        checkOutput("0099 digit0", 32'(dig_bcd), 32'h9);
        waitCycles(5);
        checkOutput("0099 digit1", 32'(dig_bcd), 32'h9);
        waitCycles(5);
        checkOutput("0099 digit2", 32'(dig_bcd), 32'(hiZero));
        waitCycles(5);
        checkOutput("0099 digit3", 32'(dig_bcd), 32'(hiZero));

        // 1111 pending, then 5555 loaded exactly in the commit cycle.
        applyStimulus(1'b1, 1'b1, 16'h1111);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 16'h5555);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("race frame_tick", 32'(frame_tick), 32'h1);
        checkOutput("race digit0 old", 32'(dig_bcd), 32'h1);
        checkOutput("race pending kept", 32'(pending), 32'h1);
        waitCycles(5);
        checkOutput("race digit1 old", 32'(dig_bcd), 32'h1);
        waitCycles(15);
        checkOutput("race next tick", 32'(frame_tick), 32'h1);
        checkOutput("race next pending", 32'(pending), 32'h0);
        checkOutput("race next digit0", 32'(dig_bcd), 32'h5);

        // Drop enable while digit 1 is driven, then load while dark.
        waitCycles(6);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        waitCycles(1);
        checkOutput("off an", 32'(an), 32'hF);
        checkOutput("off dig_bcd", 32'(dig_bcd), 32'hF);
        checkOutput("off dig_idx", 32'(dig_idx), 32'h0);
        applyStimulus(1'b0, 1'b1, 16'h0042);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("off load pending", 32'(pending), 32'h1);
        waitCycles(1);
        checkOutput("off commit pending", 32'(pending), 32'h0);
        checkOutput("off no frame_tick", 32'(frame_tick), 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(1);
        checkOutput("0042 digit0", 32'(dig_bcd), 32'h2);
        waitCycles(5);
        checkOutput("0042 digit1", 32'(dig_bcd), 32'h4);
        waitCycles(5);
        checkOutput("0042 digit2", 32'(dig_bcd), 32'(hiZero));

        // Async reset in the middle of a guard interval with a load pending.
        applyStimulus(1'b1, 1'b1, 16'h7777);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(3);
        checkOutput("guard an", 32'(an), 32'hF);
        checkOutput("guard dig_idx", 32'(dig_idx), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst dig_idx", 32'(dig_idx), 32'h0);
        checkOutput("async rst pending", 32'(pending), 32'h0);
        checkOutput("async rst an", 32'(an), 32'hF);
        checkOutput("async rst dig_bcd", 32'(dig_bcd), 32'hF);
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("post rst an", 32'(an), 32'b1110);
        checkOutput("post rst digit0 blank", 32'(dig_bcd), 32'hF);

        // Randomized phase: loads, short enable drops, A..F codes included.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 6) == 0), randBcd());
            waitCycles(1);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
